// File: rtl/lz4_byte_adv_ctrl_pkg.sv
// Shared types and sizing constants for the LZ4 byte-advance controller.
// Pure declarations; no logic, no latency, no flow control.
package lz4_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int MAX_ADV       = 4;
    localparam int DW_BYTES      = 4;
    localparam int DEF_BUF_BYTES = 8;

endpackage

// File: rtl/lz4_byte_adv_ctrl_if.sv
// Input-word and matcher-advance bundle between the reader/matcher and the controller.
// Wires only; ready/ack are driven by the controller, valid/req by the producer.
interface lz4_byte_adv_ctrl_if;
    logic        in_valid;
    logic [31:0] in_data;
    logic [2:0]  in_nbytes;
    logic        in_ready;
    logic        adv_req;
    logic [2:0]  adv_bytes;
    logic        adv_ack;
    logic [31:0] win_data;
    logic [2:0]  win_avail;
    logic [2:0]  incr_bytes;

    modport master (
        output in_valid, in_data, in_nbytes, adv_req, adv_bytes,
        input  in_ready, adv_ack, win_data, win_avail, incr_bytes
    );

    modport slave (
        input  in_valid, in_data, in_nbytes, adv_req, adv_bytes,
        output in_ready, adv_ack, win_data, win_avail, incr_bytes
    );
endinterface

// File: rtl/lz4_byte_adv_ctrl_win_buf.sv
// Byte shift window: pops n bytes from the front, then appends k bytes at fill-n.
// Pushed bytes are visible one cycle after the edge; no bypass.
// No backpressure of its own; the caller must keep fill-pop+push within the depth.
module lz4_byte_win_buf
    import lz4_ctrl_pkg::*;
#(
    parameter int BUF_BYTES = DEF_BUF_BYTES,
    parameter int FW        = $clog2(BUF_BYTES + 1)
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          clr,
    input  logic          push_en,
    input  logic [2:0]    push_k,
    input  logic [31:0]   push_dat,
    input  logic          pop_en,
    input  logic [2:0]    pop_n,
    output logic [FW-1:0] fill,
    output logic [31:0]   win_data,
    output logic [2:0]    win_avail
);

    localparam int BW = 8 * BUF_BYTES;

    logic [BW-1:0] buf_q, buf_d;
    logic [FW-1:0] fill_q, fill_d;

    // Bytes at or above fill are kept at zero, so the window output needs no mask.
    always_comb begin
        int            pop_i;
        int            push_i;
        int            base;
        logic [31:0]   kmask;
        logic [BW-1:0] kept;
        logic [BW-1:0] ins;

        pop_i  = pop_en  ? int'(pop_n)  : 0;
        push_i = push_en ? int'(push_k) : 0;
        base   = int'(fill_q) - pop_i;
        kmask  = (push_i == 0) ? 32'h0 : (32'hFFFF_FFFF >> (8 * (DW_BYTES - push_i)));
        kept   = (buf_q >> (8 * pop_i)) & ~({BW{1'b1}} << (8 * base));
        ins    = BW'(push_dat & kmask) << (8 * base);
        buf_d  = kept | ins;
        fill_d = FW'(base + push_i);
        if (clr) begin
            buf_d  = '0;
            fill_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            buf_q  <= '0;
            fill_q <= '0;
        end else begin
            buf_q  <= buf_d;
            fill_q <= fill_d;
        end
    end

    assign fill      = fill_q;
    assign win_data  = buf_q[31:0];
    assign win_avail = (fill_q >= FW'(DW_BYTES)) ? 3'd4 : fill_q[2:0];

endmodule

// File: rtl/lz4_byte_adv_ctrl.sv
// Byte-consumption sequencer: buffers reader words, grants matcher advances, drives incr_bytes.
// adv_ack/incr_bytes are same-cycle combinational; pushed bytes appear after the next edge.
// in_ready drops when the window cannot take a full word; refused advances are not queued. Option: LZ4_STALL_CNT_EN.
module lz4_byte_adv_ctrl
    import lz4_ctrl_pkg::*;
#(
    parameter int BUF_BYTES = DEF_BUF_BYTES,
    parameter int LEN_W     = 32
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 start,
    input  logic [LEN_W-1:0]     blk_len,
    lz4_byte_adv_ctrl_if.slave   io,
    output logic                 busy,
    output logic                 blk_done,
    output logic                 err_ovr,
    output logic [31:0]          stall_cnt
);

    localparam int FW = $clog2(BUF_BYTES + 1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] in_rem_q, out_rem_q, out_rem_nxt;
    logic             err_q;
    logic [FW-1:0]    fill;
    logic             start_fire, push_fire, over;
    logic [2:0]       nb, push_k;
    logic             in_ready, adv_ack;

    assign start_fire = start && (state_q == IDLE);

    // Out-of-range word sizes are clamped so the window can never overrun.
    always_comb begin
        nb        = (io.in_nbytes > 3'd4) ? 3'd4 : io.in_nbytes;
        over      = LEN_W'(nb) > in_rem_q;
        push_k    = over ? in_rem_q[2:0] : nb;
        push_fire = io.in_valid && in_ready && (nb != 3'd0);
    end

    assign out_rem_nxt = out_rem_q - (adv_ack ? LEN_W'(io.adv_bytes) : '0);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (blk_len == '0) ? DONE : RUN;
            RUN:  if (out_rem_nxt == '0) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == RUN) && (fill <= FW'(BUF_BYTES - DW_BYTES)) && (in_rem_q != '0);
        adv_ack  = (state_q == RUN) && io.adv_req && (io.adv_bytes <= io.win_avail)
                   && (LEN_W'(io.adv_bytes) <= out_rem_q);
        busy     = (state_q != IDLE);
        blk_done = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            in_rem_q  <= '0;
            out_rem_q <= '0;
            err_q     <= 1'b0;
        end else if (start_fire) begin
            in_rem_q  <= blk_len;
            out_rem_q <= blk_len;
            err_q     <= 1'b0;
        end else begin
            if (adv_ack) out_rem_q <= out_rem_nxt;
            if (push_fire) begin
                in_rem_q <= in_rem_q - LEN_W'(push_k);
                if (over) err_q <= 1'b1;
            end
        end
    end

    lz4_byte_win_buf #(
        .BUF_BYTES (BUF_BYTES),
        .FW        (FW)
    ) u_win_buf (
        .clk       (clk),
        .rstN      (rstN),
        .clr       (start_fire),
        .push_en   (push_fire),
        .push_k    (push_k),
        .push_dat  (io.in_data),
        .pop_en    (adv_ack),
        .pop_n     (io.adv_bytes),
        .fill      (fill),
        .win_data  (io.win_data),
        .win_avail (io.win_avail)
    );

    assign io.in_ready   = in_ready;
    assign io.adv_ack    = adv_ack;
    assign io.incr_bytes = adv_ack ? io.adv_bytes : 3'd0;
    assign err_ovr       = err_q;

`ifdef LZ4_STALL_CNT_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            stall_q <= '0;
        end else if (start_fire) begin
            stall_q <= '0;
        end else if ((state_q == RUN) && io.adv_req && !adv_ack && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_lz4_byte_adv_ctrl.sv
// Directed bench for lz4_byte_adv_ctrl: a byte-queue scoreboard holds accepted bytes,
// which are compared against win_data and retired as the DUT acks advances.
module tb_lz4_byte_adv_ctrl;

    logic        clk = 1'b0;
    logic        rstN;
    logic        start;
    logic [31:0] blk_len;
    logic        busy, blk_done, err_ovr;
    logic [31:0] stall_cnt;

    lz4_byte_adv_ctrl_if bus ();

    lz4_byte_adv_ctrl #(.BUF_BYTES(8), .LEN_W(32)) dut (
        .clk       (clk),
        .rstN      (rstN),
        .start     (start),
        .blk_len   (blk_len),
        .io        (bus),
        .busy      (busy),
        .blk_done  (blk_done),
        .err_ovr   (err_ovr),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    int          m_state = 0;
    logic [31:0] m_in_rem = 0;
    logic [31:0] m_out_rem = 0;
    logic        m_err = 1'b0;
    logic [31:0] m_stall = 0;
    int          incr_sum = 0;
    int          done_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_state   = 0;
        m_in_rem  = 0;
        m_out_rem = 0;
        m_err     = 1'b0;
        m_stall   = 0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
        chk({tag, "_adv_ack"}, {31'd0, bus.adv_ack}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_blk_done"}, {31'd0, blk_done}, 32'd0);
        chk({tag, "_err_ovr"}, {31'd0, err_ovr}, 32'd0);
        chk({tag, "_win_data"}, bus.win_data, 32'd0);
        chk({tag, "_win_avail"}, {29'd0, bus.win_avail}, 32'd0);
        chk({tag, "_incr"}, {29'd0, bus.incr_bytes}, 32'd0);
        chk({tag, "_stall"}, stall_cnt, 32'd0);
    endtask

    // One clock: drive at negedge, compare settled outputs against the model, then advance the model.
    task automatic step(input string tag, input logic st, input logic [31:0] len,
                        input logic iv, input logic [2:0] inn,
                        input logic rq, input logic [2:0] ab);
        int          sz, av, k;
        logic [31:0] d, ew;
        logic        e_rdy, e_ack;
        @(negedge clk);
        d             = $urandom;
        start         = st;
        blk_len       = len;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.in_nbytes = inn;
        bus.adv_req   = rq;
        bus.adv_bytes = ab;
        #2;
        sz = exp_q.size();
        av = (sz > 4) ? 4 : sz;
        ew = 32'd0;
        for (int j = 0; j < av; j++) ew[8*j +: 8] = exp_q[j];
        e_rdy = (m_state == 1) && (sz <= 4) && (m_in_rem != 0);
        e_ack = (m_state == 1) && rq && (int'(ab) <= av) && ({29'd0, ab} <= m_out_rem);
        chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, {31'd0, e_rdy});
        chk({tag, "_adv_ack"}, {31'd0, bus.adv_ack}, {31'd0, e_ack});
        chk({tag, "_incr"}, {29'd0, bus.incr_bytes}, e_ack ? {29'd0, ab} : 32'd0);
        chk({tag, "_win_avail"}, {29'd0, bus.win_avail}, av);
        chk({tag, "_win_data"}, bus.win_data, ew);
        chk({tag, "_busy"}, {31'd0, busy}, (m_state != 0) ? 32'd1 : 32'd0);
        chk({tag, "_blk_done"}, {31'd0, blk_done}, (m_state == 2) ? 32'd1 : 32'd0);
        chk({tag, "_err_ovr"}, {31'd0, err_ovr}, {31'd0, m_err});
        chk({tag, "_stall"}, stall_cnt, m_stall);
        incr_sum += int'(bus.incr_bytes);
        done_cnt += int'(blk_done);
        @(posedge clk);
        if (m_state == 1) begin
            if (e_ack) begin
                for (int j = 0; j < int'(ab); j++) void'(exp_q.pop_front());
                m_out_rem -= {29'd0, ab};
            end
            if (iv && e_rdy && (inn != 3'd0)) begin
                k = ({29'd0, inn} > m_in_rem) ? int'(m_in_rem) : int'(inn);
                for (int j = 0; j < k; j++) exp_q.push_back(d[8*j +: 8]);
                if ({29'd0, inn} > m_in_rem) m_err = 1'b1;
                m_in_rem -= k;
            end
`ifdef LZ4_STALL_CNT_EN
            if (rq && !e_ack && (m_stall != 32'hFFFF_FFFF)) m_stall++;
`endif
            if (m_out_rem == 0) m_state = 2;
        end else if (m_state == 2) begin
            m_state = 0;
        end else if (st) begin
            exp_q.delete();
            m_in_rem  = len;
            m_out_rem = len;
            m_err     = 1'b0;
            m_stall   = 0;
            m_state   = (len == 0) ? 2 : 1;
        end
    endtask

    // Feed the rest of the block and consume everything, bounded in cycles.
    task automatic finish_blk(input string tag);
        int n, a;
        for (int it = 0; it < 40 && m_state != 0; it++) begin
            n = (m_in_rem > 4) ? 4 : int'(m_in_rem);
            a = (exp_q.size() > 4) ? 4 : exp_q.size();
            step(tag, 1'b0, 32'd0, n != 0, 3'(n), 1'b1, 3'(a));
        end
        #1;
        chk({tag, "_end_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rstN          = 1'b0;
        start         = 1'b0;
        blk_len       = 32'd0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'd0;
        bus.in_nbytes = 3'd0;
        bus.adv_req   = 1'b0;
        bus.adv_bytes = 3'd0;
        #12;
        chk_reset_vals("rst");
        @(negedge clk);
        rstN = 1'b1;

        // 1: 10-byte block, words of 4/4/2, matcher always asks for 4 then re-presents 2
        incr_sum = 0;
        done_cnt = 0;
        step("t1_start", 1'b1, 32'd10, 1'b0, 3'd0, 1'b0, 3'd0);
        step("t1_a", 1'b0, 32'd0, 1'b1, 3'd4, 1'b1, 3'd4);
        step("t1_b", 1'b0, 32'd0, 1'b1, 3'd4, 1'b1, 3'd4);
        step("t1_c", 1'b0, 32'd0, 1'b1, 3'd2, 1'b1, 3'd4);
        step("t1_d", 1'b0, 32'd0, 1'b0, 3'd0, 1'b1, 3'd4);
        step("t1_e", 1'b0, 32'd0, 1'b0, 3'd0, 1'b1, 3'd2);
        step("t1_done", 1'b0, 32'd0, 1'b0, 3'd0, 1'b1, 3'd4);
        step("t1_idle", 1'b0, 32'd0, 1'b0, 3'd0, 1'b0, 3'd0);
        chk("t1_incr_sum", incr_sum, 32'd10);
        chk("t1_done_pulses", done_cnt, 32'd1);

        // 2: fill=1 refuses a 3-byte advance; after a 4-byte push it is granted
        step("t2_start", 1'b1, 32'd8, 1'b0, 3'd0, 1'b0, 3'd0);
        step("t2_push1", 1'b0, 32'd0, 1'b1, 3'd1, 1'b0, 3'd0);
        step("t2_refuse", 1'b0, 32'd0, 1'b0, 3'd0, 1'b1, 3'd3);
        step("t2_push4", 1'b0, 32'd0, 1'b1, 3'd4, 1'b1, 3'd3);
        step("t2_ack", 1'b0, 32'd0, 1'b0, 3'd0, 1'b1, 3'd3);
        step("t2_fill2", 1'b0, 32'd0, 1'b0, 3'd0, 1'b0, 3'd0);
        finish_blk("t2_fin");

        // 3: full window holds off input; pop frees it; push(4)+pop(3) from fill 4
        step("t3_start", 1'b1, 32'd16, 1'b0, 3'd0, 1'b0, 3'd0);
        step("t3_p4", 1'b0, 32'd0, 1'b1, 3'd4, 1'b0, 3'd0);
        step("t3_p1", 1'b0, 32'd0, 1'b1, 3'd1, 1'b0, 3'd0);
        step("t3_hold", 1'b0, 32'd0, 1'b1, 3'd4, 1'b0, 3'd0);
        step("t3_pop1", 1'b0, 32'd0, 1'b1, 3'd4, 1'b1, 3'd1);
        step("t3_both", 1'b0, 32'd0, 1'b1, 3'd4, 1'b1, 3'd3);
        step("t3_order", 1'b0, 32'd0, 1'b0, 3'd0, 1'b1, 3'd4);
        finish_blk("t3_fin");

        // 4: 6-byte block fed 8 bytes: excess dropped, err_ovr set, input closed
        step("t4_start", 1'b1, 32'd6, 1'b0, 3'd0, 1'b0, 3'd0);
        step("t4_p4", 1'b0, 32'd0, 1'b1, 3'd4, 1'b0, 3'd0);
        step("t4_p4b", 1'b0, 32'd0, 1'b1, 3'd4, 1'b0, 3'd0);
        step("t4_after", 1'b0, 32'd0, 1'b1, 3'd4, 1'b0, 3'd0);
        finish_blk("t4_fin");

        // 5: zero-length block, then a start during RUN that must be ignored
        done_cnt = 0;
        step("t5_start0", 1'b1, 32'd0, 1'b0, 3'd0, 1'b0, 3'd0);
        step("t5_done", 1'b0, 32'd0, 1'b0, 3'd0, 1'b1, 3'd0);
        step("t5_idle", 1'b0, 32'd0, 1'b0, 3'd0, 1'b1, 3'd0);
        chk("t5_done_pulses", done_cnt, 32'd1);
        step("t5_start12", 1'b1, 32'd12, 1'b0, 3'd0, 1'b0, 3'd0);
        step("t5_restart", 1'b1, 32'd3, 1'b1, 3'd4, 1'b0, 3'd0);
        finish_blk("t5_fin");

        // 6: reset with six bytes buffered, then stall counting on refused requests
        step("t6_start", 1'b1, 32'd16, 1'b0, 3'd0, 1'b0, 3'd0);
        step("t6_p4", 1'b0, 32'd0, 1'b1, 3'd4, 1'b0, 3'd0);
        step("t6_p2", 1'b0, 32'd0, 1'b1, 3'd2, 1'b0, 3'd0);
        step("t6_fill6", 1'b0, 32'd0, 1'b0, 3'd0, 1'b0, 3'd0);
        @(negedge clk);
        rstN = 1'b0;
        #2;
        chk_reset_vals("t6_rst");
        model_reset();
        @(negedge clk);
        rstN = 1'b1;
        step("t6_s2", 1'b1, 32'd8, 1'b0, 3'd0, 1'b0, 3'd0);
        step("t6_p1", 1'b0, 32'd0, 1'b1, 3'd1, 1'b0, 3'd0);
        for (int i = 0; i < 5; i++) step("t6_stall", 1'b0, 32'd0, 1'b0, 3'd0, 1'b1, 3'd3);
        #1;
`ifdef LZ4_STALL_CNT_EN
        chk("t6_stall5", stall_cnt, 32'd5);
`else
        chk("t6_stall_off", stall_cnt, 32'd0);
`endif
        finish_blk("t6_fin");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lz4_byte_adv_ctrl.md
# lz4_byte_adv_ctrl

Sequences byte consumption for the LZ4 front end. Accepts packed input words from the block reader and buffers them in an 8-byte window. Presents the next 4 window bytes to the hash/match stage and grants its per-cycle advance requests of 0–4 bytes. Drives `incr_bytes` of the absolute address counter, so that counter always tracks the first window byte, and signals the end of each compression block.

## Interface
- `BUF_BYTES`, default 8: window depth in bytes. Must be ≥ 8.
- `LEN_W`, default 32: width of block-length and remaining counters.
- `clk` input 1: clock, rising edge.
- `rstN` input 1: asynchronous, active-low reset.
- `start` input 1: one-cycle pulse that starts a block. Honoured only in IDLE.
- `blk_len` input LEN_W: block length in bytes. Sampled on `start`.
- `in_valid` input 1: input word valid.
- `in_data` input 32: input bytes. Byte 0 is `[7:0]`, which is the earliest.
- `in_nbytes` input 3: valid bytes in `in_data`, range 1–4, packed from byte 0.
- `in_ready` output 1: window can take one full word.
- `adv_req` input 1: matcher requests an advance.
- `adv_bytes` input 3: requested advance, range 0–4.
- `adv_ack` output 1: advance granted this cycle.
- `win_data` output 32: next 4 window bytes. Byte 0 is `[7:0]`.
- `win_avail` output 3: valid bytes in `win_data`, equal to min(fill, 4).
- `incr_bytes` output 3: to the address counter. Equals `adv_bytes` when `adv_ack`, else 0.
- `busy` output 1: state is not IDLE.
- `blk_done` output 1: one-cycle pulse at end of block.
- `err_ovr` output 1: sticky. Input bytes arrived beyond `blk_len`.
- `stall_cnt` output 32: see Configuration.

## Operation
- States:
  - IDLE → RUN on `start` with `blk_len` ≠ 0.
  - IDLE → DONE on `start` with `blk_len` = 0.
  - RUN → DONE when `out_rem` reaches 0.
  - DONE → IDLE unconditionally after one cycle. `blk_done` = 1 while in DONE.
- On `start`: `in_rem` and `out_rem` are loaded with `blk_len`, `fill` is cleared, `err_ovr` is cleared.
- `in_ready` = (state = RUN) && (fill ≤ BUF_BYTES−4) && (`in_rem` ≠ 0). It is decoded from registers only.
- Push (`in_valid` && `in_ready`):
  - Append k = min(`in_nbytes`, `in_rem`) bytes and decrement `in_rem` by k.
  - If `in_nbytes` > `in_rem`, drop the excess bytes and set `err_ovr`.
  - `in_nbytes` = 0 is treated as no push.
- `adv_ack` = (state = RUN) && `adv_req` && (`adv_bytes` ≤ `win_avail`) && (`adv_bytes` ≤ `out_rem`).
- Pop (`adv_ack`): shift the window down by `adv_bytes` and decrement `out_rem` by `adv_bytes`.
- A request with `adv_bytes` = 0 is acked and changes nothing.
- A refused request is not queued; the matcher holds or re-presents it.
- Simultaneous push and pop: fill_next = fill − pop + k. Pop is applied first, so pushed bytes land at index fill − pop.
- `win_data` bytes at or above `win_avail` are 0.
- `start` outside IDLE is ignored.
- Counters are unsigned modulo 2^LEN_W. They never underflow because of the ack guards.

## Timing
- Reset values:
  - State IDLE.
  - `fill`, `in_rem`, `out_rem` = 0.
  - `in_ready`, `adv_ack`, `busy`, `blk_done`, `err_ovr` = 0.
  - `win_data` = 0, `win_avail` = 0, `incr_bytes` = 0, `stall_cnt` = 0.
- Push to window latency: a word accepted at edge N is visible in `win_data` after edge N. There is no same-cycle bypass.
- `adv_ack` and `incr_bytes` are combinational in the same cycle as the request. The address counter steps at the next edge.
- `blk_done` asserts the cycle after the final pop and lasts exactly 1 cycle. `busy` deasserts the cycle after that.
- Reset mid-block: everything returns to reset values immediately. Buffered bytes are lost.

## Configuration
- `LZ4_STALL_CNT_EN` defined:
  - `stall_cnt` increments each cycle with state = RUN && `adv_req` && !`adv_ack`.
  - It saturates at 2^32−1 and clears on `start`.
- `LZ4_STALL_CNT_EN` undefined: `stall_cnt` is tied to 0 and no counter flops exist.

## Structure
- Package `lz4_ctrl_pkg` holds:
  - The state enum {IDLE, RUN, DONE}.
  - `MAX_ADV` = 4 and `DW_BYTES` = 4.
  - Default `BUF_BYTES` = 8.
- One sub-module, `lz4_byte_win_buf`, contains the byte shift buffer: push of k bytes, pop of n bytes, `fill` count, and the `win_data`/`win_avail` outputs.
- The top level holds the FSM, the remaining counters, the ack logic and the stall counter.

## Test plan
1. `blk_len`=10; push words of 4/4/2 bytes; `adv_req` with `adv_bytes`=4 every cycle.
   - Expect acks with `incr_bytes` 4, 4, 2. The last 2-byte request is granted as `adv_bytes`=2.
   - Sum of `incr_bytes` = 10, `blk_done` pulses once, `err_ovr`=0.
2. Window fill=1 with `adv_bytes`=3 → `adv_ack`=0, `incr_bytes`=0. After a 4-byte push → ack, fill=2.
3. Fill=5 → `in_ready`=0 with `in_valid` held. Pop 1 → `in_ready`=1 on the next cycle. Simultaneous push(4) and pop(3) from fill=4 → fill=5 and correct byte order.
4. `blk_len`=6; push 4, then 4 → only 2 bytes kept, `err_ovr`=1, `in_ready`=0 afterwards.
5. `start` with `blk_len`=0 → DONE next cycle, `blk_done` 1 cycle, no acks. `start` during RUN → ignored.
6. Assert `rstN`=0 mid-block with fill=6 → all outputs return to reset values. With `LZ4_STALL_CNT_EN`, 5 refused requests → `stall_cnt`=5.
